mux8_scan_ctrl: RTL and testbench
=================================

Name: mux8_scan_ctrl

Overview:
Sequencer that drives the 8:1 mux datapath's select and active-low enable lines. It walks a requested subset of the 8 channels, waits a programmable settle time per channel, and samples the mux output into one result byte. A command handshake starts a scan and a result handshake returns the byte. It sits between the mux block and any consumer needing a snapshot of all inputs.

Parameters:
NCH, 8, number of mux channels (fixed at 8 for this datapath)
SEL_W, 3, select width, equal to clog2(NCH)
SETTLE_CYC, 2, cycles each select value is held before sampling; must be >=1, enforced by an elaboration check
CNT_W, 4, settle counter width; must satisfy SETTLE_CYC <= 2**CNT_W

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start_valid  in  1  scan request
start_ready  out  1  high only in IDLE
chan_mask  in  NCH  channels to scan, captured on the start handshake
abort  in  1  synchronous scan cancel
mux_sel  out  SEL_W  to mux select inputs
mux_en_n  out  1  to mux enable, active low
mux_out  in  1  mux data output
res_valid  out  1  result available
res_ready  in  1  consumer accept
res_data  out  NCH  sampled bits; bit i = channel i
res_mask  out  NCH  echo of the captured mask
busy  out  1  high in SETTLE or DONE

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, mux_sel=0, mux_en_n=1, res_valid=0, res_data=0, res_mask=0, counter=0. All outputs are registered except start_ready, which is (state==IDLE).
- States: IDLE, SETTLE, DONE.
- IDLE, on start_valid&start_ready: capture mask and clear res_data.
  - Mask==0: go to DONE, so res_valid=1 on the next edge and mux_en_n stays 1.
  - Mask!=0: mux_sel=lowest set bit, mux_en_n=0, cnt=SETTLE_CYC-1, go to SETTLE.
- SETTLE, per edge:
  - abort=1 has priority: go to IDLE, mux_en_n=1, mux_sel=0, no result.
  - Else if cnt!=0: cnt--.
  - Else (cnt==0): res_data[mux_sel]<=mux_out.
    - If a set mask bit exists above mux_sel: mux_sel=that index, cnt reloads.
    - Otherwise: mux_en_n=1, res_valid=1, go to DONE.
- Latency: with k set bits, res_valid rises k*SETTLE_CYC edges after the start-handshake edge (1 edge when k=0). Each selected channel is held for exactly SETTLE_CYC cycles. Unselected channels are skipped with zero cost.
- DONE:
  - res_valid, res_data and res_mask are held stable until res_ready.
  - On res_valid&res_ready: res_valid=0, go to IDLE.
  - start_valid is ignored (start_ready=0) and abort is ignored.
  - Minimum one IDLE cycle between scans.
- Bits of res_data for unmasked channels are 0.
- mux_sel keeps its last value in DONE and returns to 0 on entry to IDLE.
- mux_out is sampled only while mux_en_n=0.
- Changes to chan_mask after capture have no effect mid-scan.

Decomposition:
- Package mux_scan_pkg: state enum (IDLE, SETTLE, DONE), NCH and SEL_W constants.
- Sub-module mux_scan_next_chan (combinational): inputs mask and current index plus a "first" flag; outputs next set index (strictly above current, or lowest when first) and a found flag.

Test Plan:
- SETTLE_CYC=2, mask=0xFF, mux inputs=0xA5 -> mux_sel steps 0..7, each held 2 cycles; res_valid 16 edges after handshake; res_data=0xA5, res_mask=0xFF.
- mask=0x24, inputs=0xFF -> only sel 2 then 5 visited; res_valid after 4 edges; res_data=0x24.
- mask=0x00 -> res_valid on next edge, res_data=0x00, mux_en_n never low.
- res_ready held low 5 cycles after res_valid, start_valid=1 throughout -> res_data stable, start_ready=0, no new scan until 1 cycle after res accept.
- abort asserted while mux_sel=3 with mask=0xFF -> next edge: IDLE, mux_en_n=1, mux_sel=0, res_valid never rises; a following scan returns a correct result.
- rst_n pulsed low mid-scan between clock edges -> outputs take reset values immediately without a clock; first scan after release behaves normally.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared constants and state encoding for the 8:1 mux scan sequencer.
package mux_scan_pkg;

    localparam int NCH   = 8;
    localparam int SEL_W = $clog2(NCH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/mux_scan_next_chan.sv
// Combinational finder: next set mask bit strictly above i_cur, or the lowest set bit when i_first.
// Zero latency; no handshake.
module mux_scan_next_chan #(
    parameter int NCH   = mux_scan_pkg::NCH,
    parameter int SEL_W = mux_scan_pkg::SEL_W
) (
    input  logic [NCH-1:0]   i_mask,
    input  logic [SEL_W-1:0] i_cur,
    input  logic             i_first,
    output logic [SEL_W-1:0] o_idx,
    output logic             o_found
);

    // Walk downwards so the last hit written is the lowest qualifying index.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (i_mask[i] && (i_first || (i > int'(i_cur)))) begin
                o_idx   = SEL_W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux8_scan_ctrl.sv
// Walks the selected mux channels, holds each SETTLE_CYC cycles, samples mux_out into one result byte.
// Result after k*SETTLE_CYC edges (1 edge for an empty mask); result held until res_ready, start stalls outside IDLE.
module mux8_scan_ctrl #(
    parameter int NCH        = mux_scan_pkg::NCH,
    parameter int SEL_W      = mux_scan_pkg::SEL_W,
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [NCH-1:0]   chan_mask,
    input  logic             abort,
    output logic [SEL_W-1:0] mux_sel,
    output logic             mux_en_n,
    input  logic             mux_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [NCH-1:0]   res_data,
    output logic [NCH-1:0]   res_mask,
    output logic             busy
);
    import mux_scan_pkg::*;

    if (SETTLE_CYC < 1) begin : g_settle_min
        $error("SETTLE_CYC must be at least 1");
    end
    if (SETTLE_CYC > (2 ** CNT_W)) begin : g_settle_fit
        $error("SETTLE_CYC does not fit in CNT_W");
    end

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYC - 1);

    state_t           r_state, w_state_nx;
    logic [SEL_W-1:0] r_sel, w_sel_nx;
    logic             r_en_n, w_en_n_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [NCH-1:0]   r_mask, w_mask_nx;
    logic [NCH-1:0]   r_data, w_data_nx;
    logic             r_res_vld, w_res_vld_nx;
    logic             r_busy;

    logic             w_first;
    logic [NCH-1:0]   w_scan_mask;
    logic [SEL_W-1:0] w_next_idx;
    logic             w_next_found;

    // In IDLE the finder looks at the live request mask, afterwards only at the captured one.
    assign w_first     = (r_state == IDLE);
    assign w_scan_mask = w_first ? chan_mask : r_mask;

    mux_scan_next_chan #(
        .NCH   (NCH),
        .SEL_W (SEL_W)
    ) u_next_chan (
        .i_mask  (w_scan_mask),
        .i_cur   (r_sel),
        .i_first (w_first),
        .o_idx   (w_next_idx),
        .o_found (w_next_found)
    );

    always_comb begin
        w_state_nx   = r_state;
        w_sel_nx     = r_sel;
        w_en_n_nx    = r_en_n;
        w_cnt_nx     = r_cnt;
        w_mask_nx    = r_mask;
        w_data_nx    = r_data;
        w_res_vld_nx = r_res_vld;
        case (r_state)
            IDLE: begin
                if (start_valid) begin
                    w_mask_nx = chan_mask;
                    w_data_nx = '0;
                    if (w_next_found) begin
                        w_sel_nx   = w_next_idx;
                        w_en_n_nx  = 1'b0;
                        w_cnt_nx   = CNT_RELOAD;
                        w_state_nx = SETTLE;
                    end else begin
                        w_state_nx = DONE;
                    end
                end
            end
            SETTLE: begin
                if (abort) begin
                    w_state_nx = IDLE;
                    w_en_n_nx  = 1'b1;
                    w_sel_nx   = '0;
                end else if (r_cnt != '0) begin
                    w_cnt_nx = r_cnt - 1'b1;
                end else begin
                    w_data_nx[r_sel] = mux_out;
                    if (w_next_found) begin
                        w_sel_nx = w_next_idx;
                        w_cnt_nx = CNT_RELOAD;
                    end else begin
                        w_en_n_nx    = 1'b1;
                        w_res_vld_nx = 1'b1;
                        w_state_nx   = DONE;
                    end
                end
            end
            DONE: begin
                // An empty-mask scan enters DONE with res_valid still low; raise it one edge later.
                if (!r_res_vld) begin
                    w_res_vld_nx = 1'b1;
                end else if (res_ready) begin
                    w_res_vld_nx = 1'b0;
                    w_sel_nx     = '0;
                    w_state_nx   = IDLE;
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_en_n_nx  = 1'b1;
                w_sel_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_sel     <= '0;
            r_en_n    <= 1'b1;
            r_cnt     <= '0;
            r_mask    <= '0;
            r_data    <= '0;
            r_res_vld <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_sel     <= w_sel_nx;
            r_en_n    <= w_en_n_nx;
            r_cnt     <= w_cnt_nx;
            r_mask    <= w_mask_nx;
            r_data    <= w_data_nx;
            r_res_vld <= w_res_vld_nx;
            r_busy    <= (w_state_nx != IDLE);
        end
    end

    assign start_ready = (r_state == IDLE);
    assign mux_sel     = r_sel;
    assign mux_en_n    = r_en_n;
    assign res_valid   = r_res_vld;
    assign res_data    = r_data;
    assign res_mask    = r_mask;
    assign busy        = r_busy;

endmodule

// File: tb/tb_mux8_scan_ctrl.sv
// Directed bench for mux8_scan_ctrl: a behavioural 8:1 mux feeds mux_out, expected results go through a scoreboard queue.
module tb_mux8_scan_ctrl;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_valid;
    logic       start_ready;
    logic [7:0] chan_mask;
    logic       abort;
    logic [2:0] mux_sel;
    logic       mux_en_n;
    logic       mux_out;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [7:0] res_mask;
    logic       busy;
    logic [7:0] mux_in;

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] mask;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    assign mux_out = mux_en_n ? 1'b0 : mux_in[mux_sel];

    mux8_scan_ctrl #(
        .NCH        (8),
        .SEL_W      (3),
        .SETTLE_CYC (S),
        .CNT_W      (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .chan_mask   (chan_mask),
        .abort       (abort),
        .mux_sel     (mux_sel),
        .mux_en_n    (mux_en_n),
        .mux_out     (mux_out),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_mask    (res_mask),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one scan; hold > 0 keeps res_ready low (with start_valid high) for that many cycles first.
    task automatic scan(input logic [7:0] m, input logic [7:0] din, input string tag, input int hold);
        int         lat;
        int         exp_lat;
        int         mism;
        logic [2:0] want[$];
        logic [2:0] trace[$];
        logic [7:0] held;
        exp_t       e;
        exp_lat = (m == 8'h00) ? 1 : S * $countones(m);
        for (int i = 0; i < 8; i++)
            if (m[i]) repeat (S) want.push_back(3'(i));
        mux_in      = din;
        chan_mask   = m;
        start_valid = 1'b1;
        check({tag, " start_ready"}, 32'(start_ready), 32'd1);
        sb.push_back('{data: din & m, mask: m});
        tick();
        start_valid = 1'b0;
        chan_mask   = ~m;
        lat = 0;
        while (!res_valid && lat < 200) begin
            if (!mux_en_n) trace.push_back(mux_sel);
            tick();
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " sel_len"}, 32'(trace.size()), 32'(want.size()));
        mism = 0;
        for (int i = 0; i < trace.size() && i < want.size(); i++)
            if (trace[i] !== want[i]) mism++;
        check({tag, " sel_seq_mismatches"}, 32'(mism), 32'd0);
        check({tag, " en_n_done"}, 32'(mux_en_n), 32'd1);
        if (hold > 0) begin
            held        = res_data;
            start_valid = 1'b1;
            chan_mask   = 8'hFF;
            for (int c = 0; c < hold; c++) begin
                tick();
                check({tag, " hold_data"}, 32'(res_data), 32'(held));
                check({tag, " hold_start_ready"}, 32'(start_ready), 32'd0);
                check({tag, " hold_valid"}, 32'(res_valid), 32'd1);
            end
        end
        res_ready = 1'b1;
        check({tag, " sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, " res_data"}, 32'(res_data), 32'(e.data));
            check({tag, " res_mask"}, 32'(res_mask), 32'(e.mask));
        end
        tick();
        res_ready = 1'b0;
        check({tag, " valid_cleared"}, 32'(res_valid), 32'd0);
        check({tag, " idle_after_accept"}, 32'({start_ready, mux_en_n, mux_sel}), 32'({1'b1, 1'b1, 3'd0}));
        start_valid = 1'b0;
    endtask

    initial begin
        int guard;
        rst_n       = 1'b0;
        start_valid = 1'b0;
        chan_mask   = 8'h00;
        abort       = 1'b0;
        res_ready   = 1'b0;
        mux_in      = 8'h00;
        #12;
        check("rst mux_en_n", 32'(mux_en_n), 32'd1);
        check("rst mux_sel", 32'(mux_sel), 32'd0);
        check("rst res_valid", 32'(res_valid), 32'd0);
        check("rst res_data", 32'(res_data), 32'd0);
        check("rst res_mask", 32'(res_mask), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst start_ready", 32'(start_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        scan(8'hFF, 8'hA5, "full", 0);
        tick();
        scan(8'h24, 8'hFF, "sparse", 0);
        tick();
        scan(8'h00, 8'h5A, "empty", 0);
        tick();
        scan(8'h81, 8'h01, "backpressure", 5);
        tick();

        // Abort once channel 3 is on the mux.
        mux_in      = 8'hFF;
        chan_mask   = 8'hFF;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        guard = 0;
        while (!(mux_sel == 3'd3 && !mux_en_n) && guard < 50) begin
            tick();
            guard++;
        end
        check("abort reached_sel3", 32'(mux_sel), 32'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort en_n", 32'(mux_en_n), 32'd1);
        check("abort sel", 32'(mux_sel), 32'd0);
        check("abort start_ready", 32'(start_ready), 32'd1);
        guard = 0;
        for (int c = 0; c < 20; c++) begin
            if (res_valid) guard++;
            tick();
        end
        check("abort no_result", 32'(guard), 32'd0);
        scan(8'h3C, 8'h96, "after_abort", 0);
        tick();

        // Asynchronous reset mid-scan, between clock edges.
        mux_in      = 8'hFF;
        chan_mask   = 8'hF0;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        repeat (3) tick();
        check("pre_rst en_n_low", 32'(mux_en_n), 32'd0);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst en_n", 32'(mux_en_n), 32'd1);
        check("async_rst sel", 32'(mux_sel), 32'd0);
        check("async_rst busy", 32'(busy), 32'd0);
        check("async_rst res_mask", 32'(res_mask), 32'd0);
        check("async_rst start_ready", 32'(start_ready), 32'd1);
        #2 rst_n = 1'b1;
        tick();
        scan(8'h42, 8'hC3, "after_rst", 0);
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
